game_tick_sched: RTL and testbench
==================================

Name: game_tick_sched

Overview:
Central timebase scheduler for the game logic. It owns one free-running prescaler that turns the system clock into a base tick. From that tick it sequences NCH independently programmable channels, such as countdown timer, bullet step, enemy spawn and blink. Each channel emits a single-cycle tick pulse after a programmed number of base ticks. Game FSMs consume these pulses, so the design no longer needs a separate divided clock per function.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BASE_HZ, 1000, base tick rate; divisor DIV = CLK_HZ/BASE_HZ, which must be an integer ≥ 2
NCH, 4, number of channels
PW, 16, width of the period and count fields, in base ticks

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  synchronous, active-low reset
cfg_we  in  1  writes cfg_period and cfg_mode into the shadow registers of channel cfg_ch
cfg_ch  in  $clog2(NCH)  channel select for the configuration write
cfg_period  in  PW  period in base ticks; 0 disables the channel
cfg_mode  in  1  0 = periodic, 1 = one-shot
start  in  NCH  per-channel start/restart request, one-cycle pulse
stop  in  NCH  per-channel stop request, one-cycle pulse
pause  in  1  level; freezes the prescaler and therefore all channels
base_tick  out  1  registered 1-cycle pulse every DIV unpaused cycles
tick  out  NCH  registered 1-cycle pulse per channel on expiry
busy  out  NCH  channel is in RUN

Behaviour:
- Reset (rst_n low at a clock edge):
  - prescaler = 0; base_tick, tick and busy = 0
  - all shadow periods = 0, all modes = periodic
  - all channels go to IDLE
  - reset applied mid-run aborts the run with no tick pulse
- Prescaler:
  - increments when pause = 0 and holds when pause = 1
  - at DIV-1 it wraps to 0 and base_tick goes high for the next cycle
  - the first base_tick occurs DIV cycles after reset release
  - pause asserted in the cycle the prescaler sits at DIV-1 suppresses that wrap until pause drops
- Configuration:
  - cfg_we updates shadow registers only
  - a running channel picks up the new values at its next load (start or periodic reload), never mid-count
- Channel FSM, states IDLE and RUN:
  - IDLE: start with shadow period ≠ 0 loads count = period and moves to RUN; busy = 1 from the next cycle. start with period = 0 is ignored.
  - RUN: on each base_tick, if count == 1, tick = 1 for one cycle. Then:
    - periodic mode: reload count = shadow period; if that period is 0, go to IDLE instead
    - one-shot mode: go to IDLE; busy falls in the same cycle that tick rises
  - RUN: on a base_tick with count > 1, decrement count.
  - RUN: start restarts the count (reloads count = period); the current interval produces no tick.
  - Any state: stop moves the channel to IDLE with no tick.
- Same-cycle priority per channel: stop > start > base_tick.
  - stop together with start leaves the channel IDLE.
  - start together with base_tick loads the count, and that base_tick is not counted.
- Timing rule: the tick appears on the period-th base_tick after start, registered one cycle later.
- Channels are fully independent. Several channels may tick in the same cycle.

Optional Feature:
GAME_TICK_FASTSIM_EN
- Defined: DIV is forced to 4 regardless of CLK_HZ/BASE_HZ, for simulation speed; all other behaviour is identical.
- Undefined: DIV = CLK_HZ/BASE_HZ.

Decomposition:
- Package game_tick_pkg holds:
  - chan_state_t enum {IDLE, RUN}
  - mode constants MODE_PERIODIC = 0 and MODE_ONESHOT = 1
  - a constant function that computes DIV, including the GAME_TICK_FASTSIM_EN override
- Sub-module game_tick_chan: one channel, containing the FSM, count, shadow registers and the tick/busy registers. The top level instantiates it NCH times from a generate loop next to the shared prescaler.

Test Plan:
All scenarios run with GAME_TICK_FASTSIM_EN defined, so DIV = 4.
1. Reset, then idle for 20 cycles → base_tick high at cycles 4, 8, 12, 16, 20; tick and busy stay 0.
2. Channel 0: period = 3, periodic, start → tick[0] every 12 cycles; exactly 5 pulses in 60 cycles; busy[0] stays 1.
3. Channel 1: period = 2, one-shot, start → a single tick[1] about 8 cycles later; busy[1] falls in the tick cycle; no further ticks over 40 cycles.
4. Channel 2: period = 0 with start → busy[2] stays 0. Then period = 5 with start and stop asserted together → stays IDLE, no tick.
5. Channel 0 running with period = 3; pause held for 10 cycles mid-interval → the next tick[0] is delayed by exactly 10 cycles and the interval is otherwise unchanged.
6. Channel 0 and channel 3 running; rst_n low for one cycle mid-count → all outputs 0 on the next cycle; start without reconfiguring → ignored, because periods were cleared to 0.

Source files
------------

// File: rtl/game_tick_pkg.sv
// Shared types and helpers for the game tick scheduler.
// Build option: GAME_TICK_FASTSIM_EN forces the prescaler divisor to 4 for fast simulation.
package game_tick_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Prescaler divisor: system clocks per base tick.
  function automatic int calc_div(input int clk_hz, input int base_hz);
`ifdef GAME_TICK_FASTSIM_EN
    calc_div = 4;
`else
    calc_div = clk_hz / base_hz;
`endif
  endfunction

endpackage

// File: rtl/game_tick_chan.sv
// One scheduler channel: shadow config, down-counter in base ticks, tick/busy outputs.
// Build option: GAME_TICK_FASTSIM_EN (affects only the shared prescaler, not this block).
//
// state | meaning
// IDLE  | channel stopped, no counting, busy = 0
// RUN   | counting base ticks down to terminal count 1, busy = 1
module game_tick_chan
  import game_tick_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_wr,
  input  logic [PW-1:0] cfg_period,
  input  logic          cfg_mode,
  input  logic          start,
  input  logic          stop,
  input  logic          base_tick,
  output logic          tick,
  output logic          busy
);

  chan_state_t   state_q, state_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] shadow_period_q;
  logic          shadow_mode_q;
  logic          run_mode_q, run_mode_d;
  logic          tick_q, tick_d;

  // Shadow registers; a running count only sees these at its next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_period_q <= '0;
      shadow_mode_q   <= MODE_PERIODIC;
    end else if (cfg_wr) begin
      shadow_period_q <= cfg_period;
      shadow_mode_q   <= cfg_mode;
    end
  end

  // State register together with the count, latched mode and tick pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      run_mode_q <= MODE_PERIODIC;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      run_mode_q <= run_mode_d;
      tick_q     <= tick_d;
    end
  end

  // Next-state: stop beats start, start beats base_tick (a coincident base tick is not counted).
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    run_mode_d = run_mode_q;
    tick_d     = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      if (shadow_period_q != '0) begin
        state_d    = RUN;
        count_d    = shadow_period_q;
        run_mode_d = shadow_mode_q;
      end else begin
        // A zero period disables the channel, also when restarting a running one.
        state_d = IDLE;
      end
    end else if (state_q == RUN && base_tick) begin
      if (count_q == PW'(1)) begin
        tick_d = 1'b1;
        if (run_mode_q == MODE_ONESHOT || shadow_period_q == '0) begin
          state_d = IDLE;
        end else begin
          count_d    = shadow_period_q;
          run_mode_d = shadow_mode_q;
        end
      end else begin
        count_d = count_q - PW'(1);
      end
    end
  end

  // Outputs: busy follows the state register so it drops in the same cycle a one-shot tick rises.
  always_comb begin
    busy = (state_q == RUN);
    tick = tick_q;
  end

endmodule

// File: rtl/game_tick_sched.sv
// Central timebase: one shared prescaler producing base_tick, feeding NCH independent channels.
// Build option: GAME_TICK_FASTSIM_EN forces the divisor to 4 instead of CLK_HZ/BASE_HZ.
module game_tick_sched
  import game_tick_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int BASE_HZ = 1000,
  parameter int NCH     = 4,
  parameter int PW      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [PW-1:0]          cfg_period,
  input  logic                   cfg_mode,
  input  logic [NCH-1:0]         start,
  input  logic [NCH-1:0]         stop,
  input  logic                   pause,
  output logic                   base_tick,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         busy
);

  localparam int DIV = calc_div(CLK_HZ, BASE_HZ);
  localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CHW = $clog2(NCH);

  logic [PSW-1:0] presc_q;

  // Prescaler: frozen while paused, so a wrap pending at DIV-1 waits for pause to drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= 1'b0;
      if (!pause) begin
        if (presc_q == PSW'(DIV - 1)) begin
          presc_q   <= '0;
          base_tick <= 1'b1;
        end else begin
          presc_q <= presc_q + PSW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic cfg_hit;
    assign cfg_hit = cfg_we && (cfg_ch == CHW'(g));

    game_tick_chan #(
      .PW(PW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_wr    (cfg_hit),
      .cfg_period(cfg_period),
      .cfg_mode  (cfg_mode),
      .start     (start[g]),
      .stop      (stop[g]),
      .base_tick (base_tick),
      .tick      (tick[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model counting base ticks to expiry.
module tb_game_tick_sched;

  localparam int NCH = 4;
  localparam int PW  = 16;
  localparam int DIV = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [PW-1:0]  cfg_period;
  logic           cfg_mode;
  logic [NCH-1:0] start;
  logic [NCH-1:0] stop;
  logic           pause;
  logic           base_tick;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int             pcnt;
  logic           exp_base;
  logic [NCH-1:0] exp_tick;
  logic [NCH-1:0] exp_busy;
  int             shp  [NCH];
  bit             shm  [NCH];
  bit             act  [NCH];
  int             left [NCH];
  bit             rm   [NCH];

  game_tick_sched #(
    .CLK_HZ (4000),
    .BASE_HZ(1000),
    .NCH    (NCH),
    .PW     (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .base_tick (base_tick),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, using the inputs as they stand at that edge.
  task automatic model_edge();
    logic           bt;
    logic [NCH-1:0] nt;
    bt = exp_base;
    nt = '0;
    if (!rst_n) begin
      pcnt     = 0;
      exp_base = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shp[i] = 0; shm[i] = 0; act[i] = 0; left[i] = 0; rm[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (stop[i]) begin
          act[i] = 0;
        end else if (start[i]) begin
          if (shp[i] != 0) begin
            act[i] = 1; left[i] = shp[i]; rm[i] = shm[i];
          end else begin
            act[i] = 0;
          end
        end else if (act[i] && bt) begin
          left[i] = left[i] - 1;
          if (left[i] == 0) begin
            nt[i] = 1'b1;
            if (rm[i] || shp[i] == 0) act[i] = 0;
            else begin
              left[i] = shp[i]; rm[i] = shm[i];
            end
          end
        end
      end
      if (cfg_we) begin
        shp[cfg_ch] = int'(cfg_period);
        shm[cfg_ch] = cfg_mode;
      end
      exp_base = 1'b0;
      if (!pause) begin
        pcnt = pcnt + 1;
        if (pcnt == DIV) begin
          pcnt     = 0;
          exp_base = 1'b1;
        end
      end
    end
    exp_tick = nt;
    for (int i = 0; i < NCH; i++) exp_busy[i] = act[i];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_base_tick", 32'(base_tick), 32'(exp_base));
    chk("model_tick", 32'(tick), 32'(exp_tick));
    chk("model_busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int ch, input int period, input bit mode);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_period = PW'(period);
    cfg_mode   = mode;
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic pulse_start(input logic [NCH-1:0] mask);
    start = mask;
    step();
    start = '0;
  endtask

  initial begin
    int  n;
    int  k;
    bit  found;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_mode = 1'b0;
    start = '0; stop = '0; pause = 1'b0;
    pcnt = 0; exp_base = 1'b0; exp_tick = '0; exp_busy = '0;
    for (int i = 0; i < NCH; i++) begin
      shp[i] = 0; shm[i] = 0; act[i] = 0; left[i] = 0; rm[i] = 0;
    end

    idle(3);
    chk("reset_base_tick", 32'(base_tick), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Scenario 1: base_tick every 4 cycles from release, channels quiet
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("s1_base_tick", 32'(base_tick), (i % 4 == 0) ? 32'd1 : 32'd0);
      chk("s1_quiet", 32'(tick | busy), 32'd0);
    end

    // Scenario 2: ch0 periodic, period 3 -> 5 ticks in any 60 cycles
    cfg(0, 3, 1'b0);
    pulse_start(4'b0001);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (tick[0]) n++;
      chk("s2_busy0", 32'(busy[0]), 32'd1);
    end
    chk("s2_pulses", 32'(n), 32'd5);

    // Scenario 3: ch1 one-shot, period 2 -> a single tick, busy drops with it
    cfg(1, 2, 1'b1);
    pulse_start(4'b0010);
    n = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      if (tick[1]) begin
        n++;
        chk("s3_busy_fall", 32'(busy[1]), 32'd0);
      end
    end
    chk("s3_pulses", 32'(n), 32'd1);
    chk("s3_busy_end", 32'(busy[1]), 32'd0);

    // Scenario 4: ch2 zero period ignored; start+stop together stays idle
    cfg(2, 0, 1'b0);
    pulse_start(4'b0100);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("s4_zero_busy", 32'(busy[2]), 32'd0);
    end
    cfg(2, 5, 1'b0);
    start = 4'b0100; stop = 4'b0100;
    step();
    start = '0; stop = '0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tick[2] || busy[2]) n++;
    end
    chk("s4_startstop", 32'(n), 32'd0);

    // Scenario 5: pause of 10 cycles stretches a 12-cycle interval to 22
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (tick[0]) found = 1'b1;
    end
    chk("s5_sync", 32'(found), 32'd1);
    k = 0;
    idle(3); k += 3;
    pause = 1'b1;
    idle(10); k += 10;
    pause = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(); k++;
      if (tick[0]) found = 1'b1;
    end
    chk("s5_interval", 32'(k), 32'd22);

    // Scenario 6: reset mid-count clears everything, including shadow periods
    cfg(3, 4, 1'b0);
    pulse_start(4'b1000);
    idle(6);
    rst_n = 1'b0;
    step();
    chk("s6_rst_base", 32'(base_tick), 32'd0);
    chk("s6_rst_tick", 32'(tick), 32'd0);
    chk("s6_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    pulse_start(4'b1001);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s6_ignored", 32'(tick | busy), 32'd0);
    end

    // Randomized phase against the model
    for (int i = 0; i < 1500; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_ch     = 2'($urandom_range(0, NCH - 1));
      cfg_period = PW'($urandom_range(0, 4));
      cfg_mode   = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 11) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 14) == 0) pause = ~pause;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
